// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared types and constants for the Viterbi frame sequencer
package viterbi_pkg;

  localparam int NUM_STATES = 4;
  localparam int ACS_LAT    = 2;

  typedef logic [$clog2(NUM_STATES)-1:0] trellis_state_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACS,
    SETTLE,
    TRACE,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/viterbi_addr_cnt.sv
// rtl/viterbi_addr_cnt.sv - load/increment/decrement address counter with terminal-count compare
module viterbi_addr_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + 1'b1;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == tc_val);

endmodule

// File: rtl/viterbi_ctrl.sv
// rtl/viterbi_ctrl.sv - Viterbi frame sequencer (ACS gating, survivor writes, traceback walk)
// Optional build macro VITERBI_TAIL_EN: zero-terminated frames, traceback starts from state 0.
module viterbi_ctrl
  import viterbi_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int MIN_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_frame_len,
  input  logic              i_abort,
  input  logic              i_sym_valid,
  output logic              o_sym_ready,
  output logic              o_acs_rst_n,
  output logic              o_en_add,
  output logic              o_surv_wr_en,
  output logic [ADDR_W-1:0] o_surv_addr,
  input  logic [1:0]        i_sel_node,
  output logic              o_tb_valid,
  input  logic              i_tb_ready,
  output logic [ADDR_W-1:0] o_tb_addr,
  output logic [1:0]        o_tb_state,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int LEN_W = ADDR_W + 1;
`ifdef VITERBI_TAIL_EN
  localparam int MIN_EFF = MIN_LEN + 2;
`else
  localparam int MIN_EFF = MIN_LEN;
`endif
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_EFF);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(2 ** ADDR_W);

  ctrl_state_t       state, state_nxt;
  logic [ADDR_W-1:0] len_m1;
  logic [1:0]        settle_cnt;
  logic [ADDR_W-1:0] wr_cnt;
  logic              wr_tc, tb_tc;
  logic              start_ok, sym_acc, tb_xfer, settle_last, abort_evt, err_nxt;

  assign abort_evt   = i_abort && (state != IDLE);
  assign start_ok    = i_start && (state == IDLE) &&
                       (i_frame_len >= LEN_MIN) && (i_frame_len <= LEN_MAX);
  // abort wins over a symbol or traceback handshake in the same cycle
  assign sym_acc     = (state == ACS) && i_sym_valid && o_sym_ready && !i_abort;
  assign tb_xfer     = (state == TRACE) && o_tb_valid && i_tb_ready && !i_abort;
  assign settle_last = (state == SETTLE) && (settle_cnt == 2'(ACS_LAT - 1)) && !i_abort;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          if (start_ok) state_nxt = CLEAR;
          else          err_nxt   = 1'b1;
        end
      end
      CLEAR:   state_nxt = ACS;
      ACS:     if (sym_acc && wr_tc) state_nxt = SETTLE;
      SETTLE:  if (settle_last) state_nxt = TRACE;
      TRACE:   if (tb_xfer && tb_tc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_evt) state_nxt = IDLE;
  end

  // every output is a register derived from the state being entered
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_sym_ready  <= 1'b0;
      o_acs_rst_n  <= 1'b1;
      o_en_add     <= 1'b0;
      o_surv_wr_en <= 1'b0;
      o_surv_addr  <= '0;
      o_tb_valid   <= 1'b0;
      o_tb_state   <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      len_m1       <= '0;
      settle_cnt   <= '0;
    end else begin
      o_sym_ready  <= (state_nxt == ACS);
      o_acs_rst_n  <= !((state_nxt == CLEAR) || abort_evt);
      o_en_add     <= sym_acc;
      o_surv_wr_en <= sym_acc;
      o_tb_valid   <= (state_nxt == TRACE);
      o_busy       <= (state_nxt != IDLE);
      o_done       <= (state_nxt == DONE);
      o_err        <= err_nxt;
      if (sym_acc)  o_surv_addr <= wr_cnt;
      if (start_ok) len_m1 <= ADDR_W'(i_frame_len - 1'b1);
      settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : 2'd0;
`ifdef VITERBI_TAIL_EN
      if (settle_last) o_tb_state <= 2'b00;
`else
      if (settle_last) o_tb_state <= i_sel_node;
`endif
    end
  end

  viterbi_addr_cnt #(.W(ADDR_W)) u_wr_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .load_val ('0),
    .inc      (sym_acc),
    .dec      (1'b0),
    .tc_val   (len_m1),
    .count    (wr_cnt),
    .tc       (wr_tc)
  );

  // traceback walks down from len-1 and parks at 0 after the last transfer
  viterbi_addr_cnt #(.W(ADDR_W)) u_tb_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (settle_last),
    .load_val (len_m1),
    .inc      (1'b0),
    .dec      (tb_xfer && !tb_tc),
    .tc_val   ('0),
    .count    (o_tb_addr),
    .tc       (tb_tc)
  );

endmodule

// File: tb/tb_viterbi_ctrl.sv
// tb/tb_viterbi_ctrl.sv - directed self-checking bench for viterbi_ctrl
module tb_viterbi_ctrl;

  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst;
  logic              i_start;
  logic [ADDR_W:0]   i_frame_len;
  logic              i_abort;
  logic              i_sym_valid;
  logic              o_sym_ready;
  logic              o_acs_rst_n;
  logic              o_en_add;
  logic              o_surv_wr_en;
  logic [ADDR_W-1:0] o_surv_addr;
  logic [1:0]        i_sel_node;
  logic              o_tb_valid;
  logic              i_tb_ready;
  logic [ADDR_W-1:0] o_tb_addr;
  logic [1:0]        o_tb_state;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  int n_run  = 0;
  int n_fail = 0;

  viterbi_ctrl #(.ADDR_W(ADDR_W), .MIN_LEN(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_frame_len  (i_frame_len),
    .i_abort      (i_abort),
    .i_sym_valid  (i_sym_valid),
    .o_sym_ready  (o_sym_ready),
    .o_acs_rst_n  (o_acs_rst_n),
    .o_en_add     (o_en_add),
    .o_surv_wr_en (o_surv_wr_en),
    .o_surv_addr  (o_surv_addr),
    .i_sel_node   (i_sel_node),
    .o_tb_valid   (o_tb_valid),
    .i_tb_ready   (i_tb_ready),
    .o_tb_addr    (o_tb_addr),
    .o_tb_state   (o_tb_state),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_state(input logic [1:0] sel);
`ifdef VITERBI_TAIL_EN
    exp_state = 2'b00;
`else
    exp_state = sel;
`endif
  endfunction

  task automatic frame(input int len, input bit toggle, input int stall_at,
                       input logic [1:0] sel, input int exp_cyc);
    int  cyc, acc, stalls, ta;
    bit  v;
    i_frame_len = (ADDR_W+1)'(len);
    i_start     = 1'b1;
    i_sel_node  = sel;
    tick; cyc = 1;
    i_start = 1'b0;
    chk("clear_busy", o_busy, 1);
    chk("clear_rstn", o_acs_rst_n, 0);
    tick; cyc++;
    chk("acs_ready", o_sym_ready, 1);
    chk("acs_rstn", o_acs_rst_n, 1);
    acc = 0;
    for (int k = 0; k < 400 && acc < len; k++) begin
      v = toggle ? (k % 2 == 0) : 1'b1;
      i_sym_valid = v;
      tick; cyc++;
      chk("en_add", o_en_add, v);
      chk("surv_wr_en", o_surv_wr_en, v);
      if (v) begin
        chk("surv_addr", o_surv_addr, acc);
        acc++;
      end
    end
    i_sym_valid = 1'b0;
    chk("ready_drop", o_sym_ready, 0);
    tick; cyc++;
    chk("settle_tb_valid", o_tb_valid, 0);
    tick; cyc++;
    chk("tb_valid", o_tb_valid, 1);
    chk("tb_state", o_tb_state, exp_state(sel));
    chk("tb_addr_first", o_tb_addr, len - 1);
    ta = len - 1;
    stalls = 0;
    for (int k = 0; k < 400; k++) begin
      if (ta == stall_at && stalls < 3) begin
        i_tb_ready = 1'b0;
        tick; cyc++; stalls++;
        chk("stall_addr", o_tb_addr, ta);
        chk("stall_valid", o_tb_valid, 1);
      end else begin
        i_tb_ready = 1'b1;
        tick; cyc++;
        if (ta == 0) break;
        ta--;
        chk("tb_addr", o_tb_addr, ta);
      end
    end
    chk("done_pulse", o_done, 1);
    chk("done_tb_valid", o_tb_valid, 0);
    chk("done_busy", o_busy, 1);
    if (exp_cyc != 0) chk("frame_cycles", cyc, exp_cyc);
    tick;
    chk("done_clear", o_done, 0);
    chk("idle_busy", o_busy, 0);
  endtask

  task automatic bad_start(input int len);
    i_frame_len = (ADDR_W+1)'(len);
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    chk("err_pulse", o_err, 1);
    chk("err_busy", o_busy, 0);
    tick;
    chk("err_clear", o_err, 0);
    chk("err_busy2", o_busy, 0);
  endtask

  initial begin
    rst = 1'b0;
    i_start = 1'b0;
    i_frame_len = '0;
    i_abort = 1'b0;
    i_sym_valid = 1'b0;
    i_sel_node = 2'b00;
    i_tb_ready = 1'b1;
    tick; tick;
    chk("rst_busy", o_busy, 0);
    chk("rst_rstn", o_acs_rst_n, 1);
    chk("rst_ready", o_sym_ready, 0);
    chk("rst_en_add", o_en_add, 0);
    chk("rst_surv_addr", o_surv_addr, 0);
    chk("rst_tb_valid", o_tb_valid, 0);
    chk("rst_tb_addr", o_tb_addr, 0);
    chk("rst_tb_state", o_tb_state, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    rst = 1'b1;
    tick;

    // basic frame: 1 clear + 8 acs + 2 settle + 8 trace + 1 done
    frame(8, 1'b0, -1, 2'b01, 20);
    // bubbles on the symbol stream
    frame(10, 1'b1, -1, 2'b11, 0);
    // length range boundaries
    bad_start(5);
    bad_start(7);
    bad_start(65);
    bad_start(0);
    frame(64, 1'b0, -1, 2'b01, 132);
    // traceback back-pressure at address 4
    frame(8, 1'b0, 4, 2'b10, 23);

    // abort after 5 symbols, with an ignored start while busy
    i_frame_len = 7'd8;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    tick;
    i_sym_valid = 1'b1;
    for (int k = 0; k < 5; k++) tick;
    chk("abort_pre_addr", o_surv_addr, 4);
    i_frame_len = 7'd5;
    i_start = 1'b1;
    i_abort = 1'b1;
    tick;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_sym_valid = 1'b0;
    chk("abort_busy", o_busy, 0);
    chk("abort_en_add", o_en_add, 0);
    chk("abort_rstn_low", o_acs_rst_n, 0);
    chk("abort_ready", o_sym_ready, 0);
    chk("busy_start_no_err", o_err, 0);
    tick;
    chk("abort_rstn_high", o_acs_rst_n, 1);
    chk("abort_no_done", o_done, 0);
    frame(8, 1'b0, -1, 2'b10, 20);

    // reset in the middle of traceback
    i_frame_len = 7'd8;
    i_start = 1'b1;
    i_sel_node = 2'b11;
    tick;
    i_start = 1'b0;
    i_sym_valid = 1'b1;
    for (int k = 0; k < 50 && !o_tb_valid; k++) tick;
    i_sym_valid = 1'b0;
    chk("trace_reached", o_tb_valid, 1);
    tick; tick;
    rst = 1'b0;
    tick;
    chk("mrst_busy", o_busy, 0);
    chk("mrst_tb_valid", o_tb_valid, 0);
    chk("mrst_tb_state", o_tb_state, 0);
    chk("mrst_tb_addr", o_tb_addr, 0);
    chk("mrst_done", o_done, 0);
    chk("mrst_rstn", o_acs_rst_n, 1);
    rst = 1'b1;
    tick;
    frame(8, 1'b0, -1, 2'b01, 20);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
